header_loader: RTL and testbench
================================

# header_loader

Receives the 24-word work block shifted out of the SDRAM memory manager and assembles it into midstate, header tail, target and nonce range. It then sweeps the nonce range through the external SHA-256d hash core and compares each result against the target. On the first hit it raises a solution claim, with the winning nonce, back to the memory manager. It sits directly downstream of the memory manager's core_out/shift_out_enable/start_out port and drives its core_in/sol_claim inputs.

## Interface
- WORDS, 24: words per work block; fixed layout below.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low.
- start_in  in  1  level from the memory manager, high while a block is being delivered.
- shift_in_enable  in  1  one-cycle valid strobe for data_in.
- data_in  in  32  block word.
- sol_response  in  1  memory manager acknowledge of a claim.
- hash_busy  in  1  hash core is occupied.
- hash_done  in  1  one-cycle pulse; hash_result is valid in the same cycle.
- hash_result  in  256  double-SHA result, big-endian numeric value.
- hash_start  out  1  one-cycle launch pulse.
- hash_midstate  out  256  registered words 0-7.
- hash_tail  out  96  registered words 8-10.
- hash_nonce  out  32  nonce under test.
- sol_claim  out  1  solution pending.
- core_in  out  32  winning nonce; 0 when no claim is pending.
- busy  out  1  high in any state other than IDLE.
- exhausted  out  1  range swept with no hit; sticky until the next block.

## Operation
- Word layout, first word shifted in is word 0:
  - 0-7: midstate; word 0 maps to [255:224].
  - 8-10: tail.
  - 11-18: target; word 11 is the MSW.
  - 19: nonce_start.
  - 20: nonce_end.
  - 21-23: reserved; captured and ignored.
- A 5-bit word counter indexes the capture registers.
- States: IDLE, LOAD, ISSUE, WAIT_HASH, CHECK, CLAIM, DONE.
- Rising edge of start_in (registered start_in was 0, current is 1) in any state:
  - clears the word counter and exhausted;
  - goes to LOAD.
- This edge is the only abort path. The current sweep is dropped.
- LOAD:
  - each shift_in_enable stores data_in at index count, then count+1.
  - when the strobe lands with count=23: nonce ← nonce_start, go to ISSUE.
- ISSUE:
  - waits while hash_busy=1;
  - otherwise pulses hash_start for one cycle with hash_nonce=nonce, then goes to WAIT_HASH.
- WAIT_HASH: on hash_done, latches hash_result into a result register, then goes to CHECK.
- CHECK, an unsigned 256-bit comparison:
  - result ≤ target → core_in ← nonce, go to CLAIM;
  - else nonce == nonce_end → exhausted ← 1, go to DONE;
  - else nonce ← nonce+1 (32-bit wrap 0xFFFFFFFF→0), go to ISSUE.
- nonce_end < nonce_start is legal. The sweep wraps through 0 and terminates only on equality.
- CLAIM:
  - sol_claim=1 and core_in held stable;
  - on sol_response=1: core_in ← 0, go to IDLE.
- DONE: holds exhausted=1, waits for the next start edge.
- Ignored inputs, with no state change:
  - shift_in_enable outside LOAD;
  - hash_done outside WAIT_HASH;
  - start_in held high after the edge.
- Start edge and shift_in_enable in the same cycle: the edge wins, the counter goes to 0 and that word is dropped.

## Timing
- Reset (reset=0 at a clock edge):
  - state=IDLE;
  - all capture registers, nonce, core_in and result register = 0;
  - sol_claim, hash_start, busy, exhausted = 0.
- hash_midstate, hash_tail and hash_nonce are straight register outputs. They stay stable from ISSUE until the next LOAD.
- Last strobe (count=23) to hash_start: 1 cycle (LOAD→ISSUE), provided hash_busy=0.
- Per-nonce overhead outside the hash core: 3 cycles (ISSUE, WAIT_HASH exit, CHECK).
- hash_done to sol_claim=1: 2 cycles (latch, CHECK). sol_claim is registered.
- sol_response to sol_claim=0: 1 cycle. sol_response can be a one-cycle pulse.
- sol_response outside CLAIM is ignored.

## Test plan
- Load and hit:
  - stimulus: start edge, 24 words with nonce_start=0x10, nonce_end=0x20, target all-F; hash model returns 0 on every nonce.
  - response: hash_nonce=0x10, sol_claim two cycles after hash_done, core_in=0x10; sol_response clears both in one cycle.
- Sweep miss:
  - stimulus: target=0, hash model returns 1; range 0x5–0x8.
  - response: exactly 4 hash_start pulses (nonces 5, 6, 7, 8), exhausted=1, sol_claim never asserted.
- Wrap:
  - stimulus: nonce_start=0xFFFFFFFE, nonce_end=0x1, hit only at nonce 0.
  - response: nonces FFFFFFFE, FFFFFFFF, 0 issued; core_in=0.
- Abort:
  - stimulus: a new start edge during WAIT_HASH, a stale hash_done, then a fresh 24-word block.
  - response: the stale done is ignored, capture registers hold the new block, the sweep restarts at the new nonce_start.
- Backpressure and reset:
  - stimulus: hash_busy=1 for 5 cycles in ISSUE.
  - response: hash_start is delayed and single.
  - stimulus: reset=0 mid-CLAIM.
  - response: next cycle sol_claim=0, core_in=0, busy=0.

Source files
------------

// File: rtl/header_loader_if.sv
// Bundle between header_loader, the upstream memory manager and the SHA-256d hash core.
// shift_in_enable qualifies data_in for exactly one cycle (no ready); hash_start and hash_done are single-cycle pulses.
interface header_loader_if;
  logic         start_in;
  logic         shift_in_enable;
  logic [31:0]  data_in;
  logic         sol_response;
  logic         hash_busy;
  logic         hash_done;
  logic [255:0] hash_result;
  logic         hash_start;
  logic [255:0] hash_midstate;
  logic [95:0]  hash_tail;
  logic [31:0]  hash_nonce;
  logic         sol_claim;
  logic [31:0]  core_in;
  logic         busy;
  logic         exhausted;
  logic [2:0]   state_dbg;

  modport slave (
    input  start_in, shift_in_enable, data_in, sol_response,
    input  hash_busy, hash_done, hash_result,
    output hash_start, hash_midstate, hash_tail, hash_nonce,
    output sol_claim, core_in, busy, exhausted, state_dbg
  );

  modport master (
    output start_in, shift_in_enable, data_in, sol_response,
    output hash_busy, hash_done, hash_result,
    input  hash_start, hash_midstate, hash_tail, hash_nonce,
    input  sol_claim, core_in, busy, exhausted, state_dbg
  );
endinterface

// File: rtl/header_loader.sv
// Captures a 24-word work block, sweeps its nonce range through the hash core
// and claims the first nonce whose hash is at or below the target.
module header_loader (
  input  logic          clk,
  input  logic          reset,
  header_loader_if.slave bus
);
  localparam int WORDS = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_HASH = 3'd3,
    CHECK     = 3'd4,
    CLAIM     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t        state;
  logic          start_q;
  logic [4:0]    count;
  logic [31:0]   blk [WORDS];
  logic [31:0]   nonce;
  logic [255:0]  result;
  logic [31:0]   core_in_q;
  logic          sol_claim_q;
  logic          hash_start_q;
  logic          busy_q;
  logic          exhausted_q;

  logic [255:0]  target;
  logic [31:0]   nonce_start;
  logic [31:0]   nonce_end;

  assign target      = {blk[11], blk[12], blk[13], blk[14],
                        blk[15], blk[16], blk[17], blk[18]};
  assign nonce_start = blk[19];
  assign nonce_end   = blk[20];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      count        <= '0;
      for (int i = 0; i < WORDS; i++) blk[i] <= '0;
      nonce        <= '0;
      result       <= '0;
      core_in_q    <= '0;
      sol_claim_q  <= 1'b0;
      hash_start_q <= 1'b0;
      busy_q       <= 1'b0;
      exhausted_q  <= 1'b0;
    end else begin
      start_q      <= bus.start_in;
      hash_start_q <= 1'b0;
      // A fresh start edge aborts whatever is in flight, including a pending claim.
      if (bus.start_in && !start_q) begin
        count       <= '0;
        exhausted_q <= 1'b0;
        sol_claim_q <= 1'b0;
        core_in_q   <= '0;
        busy_q      <= 1'b1;
        state       <= LOAD;
      end else begin
        case (state)
          LOAD: begin
            if (bus.shift_in_enable) begin
              blk[count] <= bus.data_in;
              count      <= count + 5'd1;
              if (count == 5'(WORDS - 1)) begin
                nonce <= nonce_start;
                state <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (!bus.hash_busy) begin
              hash_start_q <= 1'b1;
              state        <= WAIT_HASH;
            end
          end
          WAIT_HASH: begin
            if (bus.hash_done) begin
              result <= bus.hash_result;
              state  <= CHECK;
            end
          end
          CHECK: begin
            if (result <= target) begin
              core_in_q   <= nonce;
              sol_claim_q <= 1'b1;
              state       <= CLAIM;
            end else if (nonce == nonce_end) begin
              exhausted_q <= 1'b1;
              state       <= DONE;
            end else begin
              // Wraps through zero when the range is given end-below-start.
              nonce <= nonce + 32'd1;
              state <= ISSUE;
            end
          end
          CLAIM: begin
            if (bus.sol_response) begin
              core_in_q   <= '0;
              sol_claim_q <= 1'b0;
              busy_q      <= 1'b0;
              state       <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.hash_start    = hash_start_q;
  assign bus.hash_midstate = {blk[0], blk[1], blk[2], blk[3],
                              blk[4], blk[5], blk[6], blk[7]};
  assign bus.hash_tail     = {blk[8], blk[9], blk[10]};
  assign bus.hash_nonce    = nonce;
  assign bus.sol_claim     = sol_claim_q;
  assign bus.core_in       = core_in_q;
  assign bus.busy          = busy_q;
  assign bus.exhausted     = exhausted_q;
  assign bus.state_dbg     = state;
endmodule

// File: tb/tb_header_loader.sv
// Bench for header_loader: behavioural hash core, block driver, nonce scoreboard.
module tb_header_loader;
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd2, S_WAIT = 3'd3,
                         S_DONE = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  header_loader_if bus();
  header_loader dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: nonces expected on successive hash_start pulses
  logic [31:0]  exp_q[$];
  logic [255:0] exp_ms;
  logic [95:0]  exp_tl;
  int           last_done_cyc = 0;
  bit           claim_seen;
  logic         claim_prev = 1'b0;

  // hash model controls: 0 = every nonce hits, 1 = only hit_nonce hits, 2 = never hits
  int           mode = 0;
  int           lat = 3;
  logic [31:0]  hit_nonce = '0;
  logic [255:0] hit_val = '0;
  logic [255:0] miss_val = '1;
  logic [31:0]  mdl_nonce;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // hash core model
  initial begin
    bus.hash_done   = 1'b0;
    bus.hash_result = '0;
    forever begin
      @(negedge clk);
      if (reset && bus.hash_start) begin
        mdl_nonce = bus.hash_nonce;
        repeat (lat - 1) @(negedge clk);
        if (mode == 0 || (mode == 1 && mdl_nonce == hit_nonce))
          bus.hash_result = hit_val;
        else
          bus.hash_result = miss_val;
        bus.hash_done = 1'b1;
        @(negedge clk);
        bus.hash_done   = 1'b0;
        bus.hash_result = '0;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.hash_done) last_done_cyc = cyc;
        if (bus.hash_start) begin
          chk("start_expected", 256'(exp_q.size() != 0), 256'd1);
          if (exp_q.size() != 0) begin
            chk("start_nonce", bus.hash_nonce, exp_q.pop_front());
            chk("start_midstate", bus.hash_midstate, exp_ms);
            chk("start_tail", bus.hash_tail, exp_tl);
          end
        end
        if (bus.sol_claim && !claim_prev) begin
          claim_seen = 1'b1;
          chk("claim_latency", 256'(cyc - last_done_cyc), 256'd2);
        end
        claim_prev = bus.sol_claim;
      end else begin
        claim_prev = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic load_block(input logic [255:0] ms, input logic [95:0] tl,
                            input logic [255:0] tg, input logic [31:0] ns,
                            input logic [31:0] ne, input bit junk);
    logic [31:0] w [24];
    for (int i = 0; i < 8; i++) w[i]      = ms[255-32*i -: 32];
    for (int i = 0; i < 3; i++) w[8+i]    = tl[95-32*i -: 32];
    for (int i = 0; i < 8; i++) w[11+i]   = tg[255-32*i -: 32];
    w[19] = ns;
    w[20] = ne;
    for (int i = 21; i < 24; i++) w[i] = $urandom;
    exp_ms = ms;
    exp_tl = tl;
    // the start edge cycle may carry a strobe that must be dropped
    bus.start_in        = 1'b1;
    bus.shift_in_enable = junk;
    bus.data_in         = $urandom;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      bus.shift_in_enable = 1'b1;
      bus.data_in         = w[i];
      @(negedge clk);
    end
    bus.shift_in_enable = 1'b0;
    bus.start_in        = 1'b0;
  endtask

  task automatic wait_claim(input logic [31:0] exp_core, input int budget);
    int n;
    n = 0;
    while (!bus.sol_claim && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("claim_seen", bus.sol_claim, 1'b1);
    chk("claim_core_in", bus.core_in, exp_core);
  endtask

  task automatic respond_claim();
    bus.sol_response = 1'b1;
    @(negedge clk);
    bus.sol_response = 1'b0;
    chk("resp_sol_claim", bus.sol_claim, 1'b0);
    chk("resp_core_in", bus.core_in, 32'd0);
    chk("resp_busy", bus.busy, 1'b0);
    chk("resp_state", bus.state_dbg, S_IDLE);
  endtask

  task automatic wait_starts_drained(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("starts_drained", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b0;
    bus.start_in        = 1'b0;
    bus.shift_in_enable = 1'b0;
    bus.data_in         = '0;
    bus.sol_response    = 1'b0;
    bus.hash_busy       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state_dbg, S_IDLE);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_sol_claim", bus.sol_claim, 1'b0);
    chk("rst_core_in", bus.core_in, 32'd0);
    chk("rst_hash_start", bus.hash_start, 1'b0);
    chk("rst_exhausted", bus.exhausted, 1'b0);
    chk("rst_nonce", bus.hash_nonce, 32'd0);
    chk("rst_midstate", bus.hash_midstate, 256'd0);
    chk("rst_tail", bus.hash_tail, 96'd0);
    reset = 1'b1;
    @(negedge clk);

    // load and hit, with a junk strobe on the start edge
    mode = 0; lat = 3; hit_val = '0;
    exp_q.push_back(32'h10);
    load_block(rand256(), 96'(rand256()), '1, 32'h10, 32'h20, 1'b1);
    chk("load_state", bus.state_dbg, S_ISSUE);
    @(negedge clk);
    chk("start_latency", bus.hash_start, 1'b1);
    wait_claim(32'h10, 20);
    respond_claim();

    // sweep miss: 5..8 all above a zero target
    mode = 2; miss_val = 256'd1;
    claim_seen = 1'b0;
    for (int n = 5; n <= 8; n++) exp_q.push_back(32'(n));
    load_block(rand256(), 96'(rand256()), '0, 32'h5, 32'h8, 1'b0);
    for (int n = 0; n < 100 && !bus.exhausted; n++) @(negedge clk);
    chk("miss_exhausted", bus.exhausted, 1'b1);
    chk("miss_starts_left", 256'(exp_q.size()), 256'd0);
    repeat (10) @(negedge clk);
    chk("miss_no_claim", 256'(claim_seen), 256'd0);
    chk("miss_state", bus.state_dbg, S_DONE);
    chk("miss_busy", bus.busy, 1'b1);

    // wrap through zero, hit only at nonce 0
    mode = 1; hit_nonce = 32'h0; hit_val = '0; miss_val = '1;
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    load_block(rand256(), 96'(rand256()), 256'hFFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    chk("wrap_exhausted_cleared", bus.exhausted, 1'b0);
    wait_claim(32'h0, 100);
    chk("wrap_starts_left", 256'(exp_q.size()), 256'd0);
    respond_claim();

    // abort during WAIT_HASH; the old block's done lands while reloading
    mode = 0; lat = 6; hit_val = '0;
    exp_q.push_back(32'h100);
    load_block(rand256(), 96'(rand256()), '1, 32'h100, 32'h1FF, 1'b0);
    wait_starts_drained(20);
    chk("abort_in_wait", bus.state_dbg, S_WAIT);
    exp_q.push_back(32'h200);
    load_block(rand256(), 96'(rand256()), '1, 32'h200, 32'h2FF, 1'b0);
    wait_claim(32'h200, 100);
    respond_claim();
    lat = 3;

    // backpressure, hash equal to target, then reset in CLAIM
    mode = 1; hit_nonce = 32'h42; hit_val = 256'h1234; miss_val = '1;
    bus.hash_busy = 1'b1;
    exp_q.push_back(32'h42);
    load_block(rand256(), 96'(rand256()), 256'h1234, 32'h42, 32'h50, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_no_start", bus.hash_start, 1'b0);
    end
    chk("bp_state", bus.state_dbg, S_ISSUE);
    bus.hash_busy = 1'b0;
    wait_claim(32'h42, 50);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_claim_sol", bus.sol_claim, 1'b0);
    chk("rst_claim_core", bus.core_in, 32'd0);
    chk("rst_claim_busy", bus.busy, 1'b0);
    chk("rst_claim_state", bus.state_dbg, S_IDLE);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("final_queue", 256'(exp_q.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
